minmax_acc: RTL

MINMAX_ACC -- requirements
Module: minmax_acc

---
 rtl/modules_params_pkg.sv | 4 +
 rtl/minmax_acc.sv | 115 +++++++++++
 2 files changed

// File: rtl/modules_params_pkg.sv
// Shared default parameters for the signal-statistics blocks.
package modules_params_pkg;
    parameter int DEFAULT_WORD_LEN = 16;
endpackage

// File: rtl/minmax_acc.sv
// Per-frame signed min/max tracker with saturating sample count.
// Handshaked input stream in; a single held result is presented per frame.
module minmax_acc
    import modules_params_pkg::*;
#(
    parameter int WORD_LEN = DEFAULT_WORD_LEN,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [WORD_LEN-1:0] s_data_i,
    input  logic                s_last_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [WORD_LEN-1:0] m_max_o,
    output logic [WORD_LEN-1:0] m_min_o,
    output logic [CNT_W-1:0]    m_cnt_o
);

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACC   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                      state_reg;
    logic                        s_ready_reg;
    logic                        m_valid_reg;
    logic signed [WORD_LEN-1:0]  acc_max_reg;
    logic signed [WORD_LEN-1:0]  acc_min_reg;
    logic        [CNT_W-1:0]     acc_cnt_reg;
    logic        [WORD_LEN-1:0]  out_max_reg;
    logic        [WORD_LEN-1:0]  out_min_reg;
    logic        [CNT_W-1:0]     out_cnt_reg;

    logic signed [WORD_LEN-1:0]  data_s;
    logic                        beat;
    logic signed [WORD_LEN-1:0]  max_next;
    logic signed [WORD_LEN-1:0]  min_next;
    logic        [CNT_W-1:0]     cnt_next;

    assign data_s = s_data_i;
    assign beat   = s_valid_i && s_ready_reg;

    // Candidate statistics including the current sample; only committed on a beat.
    always_comb begin
        max_next = acc_max_reg;
        min_next = acc_min_reg;
        cnt_next = acc_cnt_reg;
        if (state_reg == ST_FIRST) begin
            max_next = data_s;
            min_next = data_s;
            cnt_next = CNT_W'(1);
        end else begin
            if (data_s > acc_max_reg) max_next = data_s;
            if (data_s < acc_min_reg) min_next = data_s;
            if (!(&acc_cnt_reg))      cnt_next = acc_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_FIRST;
            s_ready_reg <= 1'b1;
            m_valid_reg <= 1'b0;
            acc_max_reg <= '0;
            acc_min_reg <= '0;
            acc_cnt_reg <= '0;
            out_max_reg <= '0;
            out_min_reg <= '0;
            out_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_FIRST, ST_ACC: begin
                    if (beat) begin
                        acc_max_reg <= max_next;
                        acc_min_reg <= min_next;
                        acc_cnt_reg <= cnt_next;
                        if (s_last_i) begin
                            out_max_reg <= max_next;
                            out_min_reg <= min_next;
                            out_cnt_reg <= cnt_next;
                            state_reg   <= ST_HOLD;
                            s_ready_reg <= 1'b0;
                            m_valid_reg <= 1'b1;
                        end else begin
                            state_reg   <= ST_ACC;
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready_i) begin
                        state_reg   <= ST_FIRST;
                        s_ready_reg <= 1'b1;
                        m_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_FIRST;
                    s_ready_reg <= 1'b1;
                    m_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready_o = s_ready_reg;
    assign m_valid_o = m_valid_reg;
    assign m_max_o   = out_max_reg;
    assign m_min_o   = out_min_reg;
    assign m_cnt_o   = out_cnt_reg;

endmodule
